// File: rtl/tetris_pkg.sv
// Shared types for the button-to-command encoder: the command_t token
// encoding, the button count and the fixed-priority pick helper.
package tetris_pkg;

  typedef enum logic [1:0] {
    CMD_ROTATE    = 2'd0,
    CMD_SOFT_DROP = 2'd1,
    CMD_LEFT      = 2'd2,
    CMD_RIGHT     = 2'd3
  } command_t;

  localparam int NUM_CMDS = 4;

  // Lowest set bit wins: ROTATE > SOFT_DROP > LEFT > RIGHT.
  // Returns CMD_ROTATE when nothing is pending; callers gate on |pending.
  function automatic command_t cmd_priority_pick(logic [3:0] pending);
    command_t pick;
    pick = CMD_ROTATE;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (pending[i]) pick = command_t'(2'(i));
    end
    return pick;
  endfunction

endpackage

// File: rtl/tetris_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter, stable level and a
// one-cycle registered pulse on an accepted 0->1 change of the stable level.
module tetris_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1; reaching the last value
  // with disagreement still present means the level is accepted.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             press_q;

  // Synchronise, count disagreeing samples, accept level after a full run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
        press_q  <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/tetris_cmd_encoder.sv
// Button-to-command_t producer: per-button debounce, optional auto-repeat
// (TETRIS_AUTO_REPEAT_EN), pending-flag merge, fixed-priority arbiter and a
// registered valid/ready output stage.
module tetris_cmd_encoder
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 3000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_i,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd,
  output logic [3:0] btn_state,
  output logic [7:0] drop_count
);

  logic [NUM_CMDS-1:0] stable;
  logic [NUM_CMDS-1:0] press;
  logic [NUM_CMDS-1:0] ev;
  logic [NUM_CMDS-1:0] pend_q, pend_d;
  logic [NUM_CMDS-1:0] clr;
  logic [NUM_CMDS-1:0] merge;
  logic                valid_q;
  command_t            cmd_q;
  command_t            pick;
  logic [7:0]          drop_q;
  logic                load;
  logic                take;
  logic [2:0]          n_merge;
  logic [8:0]          drop_sum;

  tetris_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db [NUM_CMDS-1:0] (
    .clk     (clk),
    .rst_n   (reset_n),
    .btn_i   (btn_i),
    .stable_o(stable),
    .press_o (press)
  );

`ifdef TETRIS_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [NUM_CMDS-1:0] rep;

  // ROTATE is a one-shot action and never repeats.
  assign rep[0] = 1'b0;

  for (genvar g = 1; g < NUM_CMDS; g++) begin : g_rpt
    logic             act_q;
    logic             first_q;
    logic [RPT_W-1:0] cnt_q;

    // cnt_q equals cycles since the press (or since the last repeat).
    assign rep[g] = act_q & stable[g] &
                    (cnt_q == (first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD)));

    // Arm on press, free-run while held, cancel when the stable level drops.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        act_q   <= 1'b0;
        first_q <= 1'b0;
        cnt_q   <= '0;
      end else if (press[g]) begin
        act_q   <= 1'b1;
        first_q <= 1'b1;
        cnt_q   <= RPT_W'(1);
      end else if (!stable[g]) begin
        act_q <= 1'b0;
      end else if (act_q) begin
        if (rep[g]) begin
          first_q <= 1'b0;
          cnt_q   <= RPT_W'(1);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign ev = press | rep;
`else
  assign ev = press;
`endif

  // Arbitration and pending-flag bookkeeping; an event hitting its own bit
  // while that bit is being loaded re-sets it and is not a drop.
  always_comb begin
    load  = ~valid_q | cmd_ready;
    take  = load & (|pend_q);
    pick  = cmd_priority_pick(pend_q);
    clr   = '0;
    if (take) clr[pick] = 1'b1;
    merge  = ev & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | ev;
    n_merge = '0;
    for (int i = 0; i < NUM_CMDS; i++) n_merge = n_merge + {2'b00, merge[i]};
    drop_sum = {1'b0, drop_q} + {6'b0, n_merge};
  end

  // Pending flags, saturating drop counter and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_ROTATE;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (load) begin
        valid_q <= take;
        if (take) cmd_q <= pick;
      end
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd        = cmd_q;
  assign btn_state  = stable;
  assign drop_count = drop_q;

endmodule
